// File: rtl/lab2_proc_mem_stage.sv
// Memory stage of a single-issue processor: takes one X-stage result at a time,
// performs the data-memory access for lw/sw and presents the writeback.

module lab2_proc_mem_stage (
    input  logic        clk,
    input  logic        reset,

    input  logic        x_val,
    output logic        x_rdy,
    input  logic [1:0]  x_type,
    input  logic [31:0] x_result,
    input  logic [31:0] x_wdata,
    input  logic [4:0]  x_rf_waddr,
    input  logic        x_rf_wen,

    output logic        dmemreq_val,
    input  logic        dmemreq_rdy,
    output logic        dmemreq_type,
    output logic [31:0] dmemreq_addr,
    output logic [31:0] dmemreq_data,

    input  logic        dmemresp_val,
    output logic        dmemresp_rdy,
    input  logic [31:0] dmemresp_data,

    output logic        w_val,
    input  logic        w_rdy,
    output logic [31:0] w_data,
    output logic [4:0]  w_rf_waddr,
    output logic        w_rf_wen
);

    // state | meaning
    // IDLE  | empty, accepting an X-stage result
    // REQ   | presenting the data-memory request
    // WAIT  | waiting for the data-memory response
    // DONE  | presenting the writeback; may accept the next entry when w_rdy = 1

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_LW = 2'd1;
    localparam logic [1:0] TYPE_SW = 2'd2;

    state_t      state;
    logic [1:0]  cap_type;
    logic [31:0] cap_result;
    logic [31:0] cap_wdata;
    logic [4:0]  cap_waddr;
    logic        cap_wen;
    logic [31:0] load_data;

    logic x_go;
    logic req_go;
    logic resp_go;
    logic x_is_mem;
    logic cap_is_lw;
    logic cap_is_sw;

    assign x_go      = x_val && x_rdy;
    assign req_go    = dmemreq_val && dmemreq_rdy;
    assign resp_go   = dmemresp_val && dmemresp_rdy;
    assign x_is_mem  = (x_type == TYPE_LW) || (x_type == TYPE_SW);
    assign cap_is_lw = (cap_type == TYPE_LW);
    assign cap_is_sw = (cap_type == TYPE_SW);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cap_type   <= 2'd0;
            cap_result <= 32'd0;
            cap_wdata  <= 32'd0;
            cap_waddr  <= 5'd0;
            cap_wen    <= 1'b0;
            load_data  <= 32'd0;
        end else if (x_go) begin
            // x_rdy is only high in IDLE, or in DONE when the writeback also completes
            cap_type   <= x_type;
            cap_result <= x_result;
            cap_wdata  <= x_wdata;
            cap_waddr  <= x_rf_waddr;
            cap_wen    <= x_rf_wen;
            state      <= x_is_mem ? REQ : DONE;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                REQ: begin
                    if (req_go) state <= WAIT;
                end
                WAIT: begin
                    if (resp_go) begin
                        if (cap_is_lw) load_data <= dmemresp_data;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (w_val && w_rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        x_rdy        = 1'b0;
        dmemreq_val  = 1'b0;
        dmemreq_type = 1'b0;
        dmemreq_addr = 32'd0;
        dmemreq_data = 32'd0;
        dmemresp_rdy = 1'b0;
        w_val        = 1'b0;
        w_data       = 32'd0;
        w_rf_waddr   = 5'd0;
        w_rf_wen     = 1'b0;

        if (!reset) begin
            x_rdy = 1'b1;
        end else begin
            case (state)
                IDLE: x_rdy = 1'b1;
                REQ: begin
                    dmemreq_val  = 1'b1;
                    dmemreq_type = cap_is_sw;
                    dmemreq_addr = cap_result;
                    dmemreq_data = cap_is_sw ? cap_wdata : 32'd0;
                end
                WAIT: dmemresp_rdy = 1'b1;
                DONE: begin
                    x_rdy      = w_rdy;
                    w_val      = 1'b1;
                    w_data     = cap_is_lw ? load_data : cap_result;
                    w_rf_waddr = cap_waddr;
                    w_rf_wen   = cap_wen && !cap_is_sw;
                end
                default: x_rdy = 1'b0;
            endcase
        end
    end

endmodule
